// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO of 2**FIFO_AW bytes drained LSB-first onto an idle-high line.
// Push to line-low latency is 2 cycles; pushes while full are dropped, back-to-back frames have no gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_AW      = 4
) (
  input  logic       sysclk,
  input  logic       cpu_resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       uart_rx_out
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]    BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH    = (FIFO_AW+1)'(2**FIFO_AW);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [BW-1:0]      baud, baud_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [7:0]         shift, shift_nxt;
  logic               line_nxt, push, pop, bit_end;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE) || !empty;
  assign push    = wr_en && !full;
  assign bit_end = (baud == BAUD_MAX);

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The FSM only pops on registered !empty, so a byte pushed this cycle is seen next cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    baud_nxt  = baud + BW'(1);
    idx_nxt   = idx;
    shift_nxt = shift;
    case (state)
      IDLE: begin
        baud_nxt = baud;
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
          shift_nxt = mem[rd_ptr];
          baud_nxt  = '0;
          idx_nxt   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
            shift_nxt = mem[rd_ptr];
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_nxt = 1'b1;
    case (state)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shift[0];
      default: line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state       <= IDLE;
      baud        <= '0;
      idx         <= '0;
      shift       <= '0;
      uart_rx_out <= 1'b1;
    end else begin
      state       <= state_nxt;
      baud        <= baud_nxt;
      idx         <= idx_nxt;
      shift       <= shift_nxt;
      uart_rx_out <= line_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at CLKS_PER_BIT=4: a line monitor decodes frames against a queue of expected bytes.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic       sysclk = 1'b0;
  logic       cpu_resetn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, uart_rx_out;

  int n_cmp = 0;
  int n_err = 0;
  int frames = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .busy(busy), .uart_rx_out(uart_rx_out)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Line monitor: samples every cycle, decodes a 10-bit frame and checks it against the queue head.
  bit         mon_on = 0;
  bit         mon_glitch = 0;
  int         mon_c = 0;
  logic [9:0] mon_bits = '0;
  logic [7:0] mon_exp;
  always @(negedge sysclk) begin
    if (!cpu_resetn) begin
      mon_on = 0;
    end else if (mon_on) begin
      if (mon_c % CPB == 0) mon_bits[mon_c / CPB] = uart_rx_out;
      else if (uart_rx_out !== mon_bits[mon_c / CPB]) mon_glitch = 1;
      if (mon_c == 10 * CPB - 1) begin
        mon_on = 0;
        frames++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL frame_unexpected: got byte %02h, required no frame", mon_bits[8:1]);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({mon_glitch, mon_bits[9], mon_bits[0], mon_bits[8:1]} !== {1'b0, 1'b1, 1'b0, mon_exp}) begin
            n_err++;
            $display("FAIL frame: got data=%02h start=%b stop=%b glitch=%b, required data=%02h start=0 stop=1 glitch=0",
                     mon_bits[8:1], mon_bits[0], mon_bits[9], mon_glitch, mon_exp);
          end
        end
      end
      mon_c++;
    end else if (uart_rx_out === 1'b0) begin
      mon_on     = 1;
      mon_c      = 1;
      mon_bits   = '0;
      mon_glitch = 0;
    end
  end

  // Advance to 1 time unit after clock edge number t.
  task automatic go_to(input int t);
    while (cyc < t) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic test_reset();
    int t;
    cpu_resetn = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h3C;
    repeat (5) @(posedge sysclk);
    #1;
    n_cmp++; if (uart_rx_out !== 1'b1) begin n_err++; $display("FAIL reset_line: got %b required 1", uart_rx_out); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b required 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b required 0", full); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    wr_en = 1'b0;
    cpu_resetn = 1'b1;
    t = cyc;
    go_to(t + 20);
    n_cmp++; if (frames !== 0) begin n_err++; $display("FAIL reset_no_frame: got %0d frames required 0", frames); end
    n_cmp++; if (busy !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL reset_after: got busy=%b empty=%b required busy=0 empty=1", busy, empty); end
  endtask

  task automatic test_single();
    int n0;
    wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
    @(posedge sysclk); #1;
    n0 = cyc; wr_en = 1'b0;
    n_cmp++; if (empty !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_push: got empty=%b busy=%b required 0 1", empty, busy); end
    go_to(n0 + 1);
    n_cmp++; if (empty !== 1'b1 || uart_rx_out !== 1'b1) begin n_err++; $display("FAIL single_pop: got empty=%b line=%b required 1 1", empty, uart_rx_out); end
    go_to(n0 + 2);
    n_cmp++; if (uart_rx_out !== 1'b0) begin n_err++; $display("FAIL single_start_edge: got %b required 0", uart_rx_out); end
    go_to(n0 + 5);
    n_cmp++; if (uart_rx_out !== 1'b0) begin n_err++; $display("FAIL single_start_end: got %b required 0", uart_rx_out); end
    go_to(n0 + 6);
    n_cmp++; if (uart_rx_out !== 1'b1) begin n_err++; $display("FAIL single_bit0: got %b required 1", uart_rx_out); end
    go_to(n0 + 10);
    n_cmp++; if (uart_rx_out !== 1'b0) begin n_err++; $display("FAIL single_bit1: got %b required 0", uart_rx_out); end
    go_to(n0 + 40);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_stop: got %b required 1", busy); end
    go_to(n0 + 42);
    n_cmp++; if (busy !== 1'b0 || uart_rx_out !== 1'b1) begin n_err++; $display("FAIL single_done: got busy=%b line=%b required 0 1", busy, uart_rx_out); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL single_drained: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int n0;
    wr_en = 1'b1; wr_data = 8'h00; exp_q.push_back(8'h00);
    @(posedge sysclk); #1;
    n0 = cyc;
    wr_data = 8'hFF; exp_q.push_back(8'hFF);
    @(posedge sysclk); #1;
    wr_en = 1'b0;
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL b2b_push_pop_count: got empty=%b required 0", empty); end
    go_to(n0 + 41);
    n_cmp++; if (uart_rx_out !== 1'b1) begin n_err++; $display("FAIL b2b_stop: got %b required 1", uart_rx_out); end
    go_to(n0 + 42);
    n_cmp++; if (uart_rx_out !== 1'b0) begin n_err++; $display("FAIL b2b_no_gap: got %b required 0", uart_rx_out); end
    go_to(n0 + 81);
    n_cmp++; if (uart_rx_out !== 1'b1) begin n_err++; $display("FAIL b2b_second_stop: got %b required 1", uart_rx_out); end
    go_to(n0 + 82);
    n_cmp++; if (busy !== 1'b0 || exp_q.size() !== 0) begin n_err++; $display("FAIL b2b_done: got busy=%b pending=%0d required 0 0", busy, exp_q.size()); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      if (i <= 16) exp_q.push_back(8'(i));
      @(posedge sysclk); #1;
      if (i == 15) begin n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL ovf_not_full: got %b required 0", full); end end
      if (i == 16) begin n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b required 1", full); end end
      if (i == 17) begin n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_drop_full: got %b required 1", full); end end
    end
    wr_en = 1'b0;
    for (int k = 0; k < 17 * 10 * CPB + 100 && exp_q.size() != 0; k++) @(negedge sysclk);
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL ovf_drain: got %0d pending required 0", exp_q.size()); end
    repeat (3) @(posedge sysclk); #1;
    n_cmp++; if (empty !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got empty=%b busy=%b required 1 0", empty, busy); end
  endtask

  task automatic test_push_while_full();
    int n0;
    wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
    @(posedge sysclk); #1;
    n0 = cyc;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h30 + 8'(i); exp_q.push_back(8'h30 + 8'(i));
      @(posedge sysclk); #1;
    end
    wr_en = 1'b0;
    go_to(n0 + 40);
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL pwf_full: got %b required 1", full); end
    wr_en = 1'b1; wr_data = 8'hAA;
    @(posedge sysclk); #1;
    wr_en = 1'b0;
    n_cmp++; if (full !== 1'b0 || empty !== 1'b0) begin n_err++; $display("FAIL pwf_count15: got full=%b empty=%b required 0 0", full, empty); end
    go_to(n0 + 42);
    n_cmp++; if (uart_rx_out !== 1'b0) begin n_err++; $display("FAIL pwf_next_start: got %b required 0", uart_rx_out); end
    for (int k = 0; k < 17 * 10 * CPB + 100 && exp_q.size() != 0; k++) @(negedge sysclk);
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL pwf_drain: got %0d pending required 0", exp_q.size()); end
    repeat (CPB * 10 + 5) @(posedge sysclk); #1;
    n_cmp++; if (busy !== 1'b0 || frames !== 1 + 2 + 17 + 17) begin n_err++; $display("FAIL pwf_idle: got busy=%b frames=%0d required 0 37", busy, frames); end
  endtask

  task automatic test_reset_mid();
    int n0;
    wr_en = 1'b1; wr_data = 8'hC3; exp_q.push_back(8'hC3);
    @(posedge sysclk); #1;
    n0 = cyc;
    wr_data = 8'h99; exp_q.push_back(8'h99);
    @(posedge sysclk); #1;
    wr_en = 1'b0;
    go_to(n0 + 19);
    n_cmp++; if (uart_rx_out !== 1'b0 || empty !== 1'b0) begin n_err++; $display("FAIL mid_before: got line=%b empty=%b required 0 0", uart_rx_out, empty); end
    #2 cpu_resetn = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++; if (uart_rx_out !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL mid_async: got line=%b empty=%b busy=%b required 1 1 0", uart_rx_out, empty, busy); end
    repeat (2) @(posedge sysclk); #1;
    cpu_resetn = 1'b1;
    @(posedge sysclk); #1;
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(posedge sysclk); #1;
    n0 = cyc; wr_en = 1'b0;
    go_to(n0 + 1);
    n_cmp++; if (uart_rx_out !== 1'b1) begin n_err++; $display("FAIL mid_idle: got %b required 1", uart_rx_out); end
    go_to(n0 + 2);
    n_cmp++; if (uart_rx_out !== 1'b0) begin n_err++; $display("FAIL mid_start: got %b required 0", uart_rx_out); end
    go_to(n0 + 42);
    n_cmp++; if (busy !== 1'b0 || exp_q.size() !== 0) begin n_err++; $display("FAIL mid_done: got busy=%b pending=%0d required 0 0", busy, exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_while_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
